read_stage_rr_arbiter_n: RTL and testbench
==========================================

// Module: read_stage_rr_arbiter_n
// PURPOSE
// - N-way round-robin arbiter for VRF read-stage requests, with a registered output stage.
// - Merges per-lane read requesters (vs/offset/groupIndex/readSource/instructionIndex) into one VRF read port.
// - Generalises the fixed 2-input combinational read arbiter: any input count, rotating pointer, 1-cycle registered out.
// PARAMETERS
// - N_IN    4  number of requesters (>=1)
// - VS_W    5  vs field width
// - OFF_W   5  offset field width
// - GRP_W   4  groupIndex field width
// - SRC_W   4  readSource field width
// - IDX_W   3  instructionIndex field width
// - PTR_W   (N_IN>1 ? $clog2(N_IN) : 1)  derived, do not override
// PORTS
// - clock                        in   1            sole clock, rising edge
// - reset                        in   1            asynchronous, active-low reset
// - io_in_valid                  in   N_IN         per-requester valid
// - io_in_ready                  out  N_IN         per-requester ready (at most one bit set)
// - io_in_bits_vs                in   N_IN*VS_W    packed, requester i at [i*VS_W +: VS_W]
// - io_in_bits_offset            in   N_IN*OFF_W   packed likewise
// - io_in_bits_groupIndex        in   N_IN*GRP_W   packed likewise
// - io_in_bits_readSource        in   N_IN*SRC_W   packed likewise
// - io_in_bits_instructionIndex  in   N_IN*IDX_W   packed likewise
// - io_out_ready                 in   1            downstream ready
// - io_out_valid                 out  1            registered valid
// - io_out_bits_{vs,offset,groupIndex,readSource,instructionIndex}  out  field widths  registered payload
// - io_out_grant                 out  PTR_W        index of the requester that produced the current output
// BEHAVIOUR
// - ptr (PTR_W reg): highest-priority index. Winner g = first i with io_in_valid[i], scanning ptr, ptr+1, ... mod N_IN.
// - can_acc: stage can take a beat this cycle (see CONFIGURATION). io_in_ready[i] = can_acc & any_valid & (i==g).
// - ready never asserted to a non-winner. Ready never asserted while no input is valid.
// - Accept = io_in_valid[g] & io_in_ready[g]. On accept, ptr <= (g+1) mod N_IN; otherwise ptr holds.
// - A stall or empty cycle never moves ptr.
// - Latency: beat accepted at edge k -> io_out_valid and payload visible after edge k (1 cycle).
// - Out handshake: io_out_valid & io_out_ready pops. Payload and grant stay stable while valid & !ready.
// - Simultaneous pop and accept in the same cycle: new beat replaces old. Full throughput of 1 beat/cycle.
// - N_IN==1: ptr is constant 0. Block is a 1-deep pipe register.
// - Reset asserted (async, any time): io_out_valid=0, ptr=0, all payload/grant regs=0, storage emptied.
// - While reset is asserted, io_in_ready=0. In-flight beats are dropped.
// - After reset release, input 0 has highest priority.
// - Payload is pure pass-through, no arithmetic. ptr wrap: (N_IN-1)+1 -> 0, including non-power-of-2 N_IN.
// CONFIGURATION
// - Macro READ_STAGE_ARB_SKID_EN.
// - Defined: output stage is a 2-entry skid (main + skid reg).
//   - can_acc = !skid_full, driven purely from a register, so no io_out_ready -> io_in_ready comb path.
//   - On stall with main full, one more beat is accepted into skid, then ready drops.
//   - On pop, skid moves to main. Order is preserved.
// - Undefined: single pipe reg, can_acc = !io_out_valid | io_out_ready (combinational ready path).
// - Both builds: identical grant order, 1-cycle latency, and reset values.
// TESTING
// - N_IN=4, all valid, out_ready=1 from reset -> grants 0,1,2,3,0.
//   - io_out_valid from cycle 1; io_out_grant follows the same sequence one cycle later.
// - Only in2 valid for 3 cycles -> in_ready=4'b0100 each cycle, ptr=3.
//   - Then in0+in2 valid -> grant 0, then 2.
// - Payload: in1 vs=5'h1f offset=5'h0a grp=4'h6 src=4'h3 idx=3'h5, others idle.
//   - Next cycle io_out_* equal those values, io_out_grant=1.
// - All valid, out_ready=0 for 4 cycles -> output holds and ptr frozen.
//   - No skid: in_ready=0 after the first beat.
//   - SKID_EN: exactly 2 beats accepted, then in_ready=0; release drains them in order.
// - Assert reset with io_out_valid=1 and stalled -> io_out_valid=0 immediately (no clock edge), in_ready=0.
//   - After release with all valid -> first grant is 0.
// - N_IN=3, all valid -> grants 0,1,2,0 (wrap on non-power-of-2).
//   - N_IN=1 -> pass-through with 1-cycle latency, grant=0.

Source files
------------

// File: rtl/read_stage_rr_arbiter_n.sv
// N-way round-robin VRF read-request arbiter with a registered output stage.
// Define READ_STAGE_ARB_SKID_EN for a 2-entry skid output (ready driven purely from a register).
module read_stage_rr_arbiter_n #(
  parameter int N_IN  = 4,
  parameter int VS_W  = 5,
  parameter int OFF_W = 5,
  parameter int GRP_W = 4,
  parameter int SRC_W = 4,
  parameter int IDX_W = 3,
  parameter int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_IN-1:0]         io_in_valid,
  output logic [N_IN-1:0]         io_in_ready,
  input  logic [N_IN*VS_W-1:0]    io_in_bits_vs,
  input  logic [N_IN*OFF_W-1:0]   io_in_bits_offset,
  input  logic [N_IN*GRP_W-1:0]   io_in_bits_groupIndex,
  input  logic [N_IN*SRC_W-1:0]   io_in_bits_readSource,
  input  logic [N_IN*IDX_W-1:0]   io_in_bits_instructionIndex,
  input  logic                    io_out_ready,
  output logic                    io_out_valid,
  output logic [VS_W-1:0]         io_out_bits_vs,
  output logic [OFF_W-1:0]        io_out_bits_offset,
  output logic [GRP_W-1:0]        io_out_bits_groupIndex,
  output logic [SRC_W-1:0]        io_out_bits_readSource,
  output logic [IDX_W-1:0]        io_out_bits_instructionIndex,
  output logic [PTR_W-1:0]        io_out_grant
);

  typedef struct packed {
    logic [PTR_W-1:0] grant;
    logic [IDX_W-1:0] idx;
    logic [SRC_W-1:0] src;
    logic [GRP_W-1:0] grp;
    logic [OFF_W-1:0] off;
    logic [VS_W-1:0]  vs;
  } beat_t;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] lo;
  logic [PTR_W-1:0] hi;
  logic             found_lo;
  logic             found_hi;
  logic             any_valid;
  logic             can_acc;
  logic             accept;
  logic             pop;
  logic             main_valid;
  beat_t            main_q;
  beat_t            in_beat;

  // Rotating priority: lowest valid index at or above ptr, else lowest valid overall.
  always_comb begin
    lo       = '0;
    hi       = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (io_in_valid[i]) begin
        if (!found_lo) begin
          lo       = PTR_W'(i);
          found_lo = 1'b1;
        end
        if (!found_hi && (i >= 32'(ptr))) begin
          hi       = PTR_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    win       = found_hi ? hi : lo;
    any_valid = found_lo;
  end

  always_comb begin
    in_beat       = '0;
    in_beat.grant = win;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (PTR_W'(i) == win) begin
        in_beat.vs  = io_in_bits_vs[i*VS_W +: VS_W];
        in_beat.off = io_in_bits_offset[i*OFF_W +: OFF_W];
        in_beat.grp = io_in_bits_groupIndex[i*GRP_W +: GRP_W];
        in_beat.src = io_in_bits_readSource[i*SRC_W +: SRC_W];
        in_beat.idx = io_in_bits_instructionIndex[i*IDX_W +: IDX_W];
      end
    end
  end

  assign accept = reset & can_acc & any_valid;
  assign pop    = main_valid & io_out_ready;

  always_comb begin
    io_in_ready = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      io_in_ready[i] = accept & (PTR_W'(i) == win);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win == PTR_W'(N_IN - 1)) ? '0 : win + 1'b1;
    end
  end

`ifdef READ_STAGE_ARB_SKID_EN
  logic  skid_valid;
  beat_t skid_q;

  assign can_acc = !skid_valid;

  // Skid only fills while main is stalled; on pop it refills main so order is kept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (!main_valid || pop) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= accept;
        if (accept) skid_q <= in_beat;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= in_beat;
      end
    end else if (accept) begin
      skid_q     <= in_beat;
      skid_valid <= 1'b1;
    end
  end
`else
  assign can_acc = !main_valid | io_out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_q     <= '0;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_q     <= in_beat;
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end
`endif

  assign io_out_valid                 = main_valid;
  assign io_out_bits_vs               = main_q.vs;
  assign io_out_bits_offset           = main_q.off;
  assign io_out_bits_groupIndex       = main_q.grp;
  assign io_out_bits_readSource       = main_q.src;
  assign io_out_bits_instructionIndex = main_q.idx;
  assign io_out_grant                 = main_q.grant;

endmodule

// File: tb/tb_read_stage_rr_arbiter_n.sv
// Directed bench for read_stage_rr_arbiter_n: N_IN=4, 3 and 1 instances on a shared clock/reset.
module tb_read_stage_rr_arbiter_n;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // N_IN = 4
  logic [3:0]  v4, r4;
  logic [19:0] vs4, off4;
  logic [15:0] grp4, src4;
  logic [11:0] idx4;
  logic        ord4, ov4;
  logic [4:0]  ovs4, ooff4;
  logic [3:0]  ogrp4, osrc4;
  logic [2:0]  oidx4;
  logic [1:0]  og4;

  // N_IN = 3
  logic [2:0]  v3, r3;
  logic [14:0] vs3, off3;
  logic [11:0] grp3, src3;
  logic [8:0]  idx3;
  logic        ord3, ov3;
  logic [4:0]  ovs3, ooff3;
  logic [3:0]  ogrp3, osrc3;
  logic [2:0]  oidx3;
  logic [1:0]  og3;

  // N_IN = 1
  logic        v1, r1;
  logic [4:0]  vs1, off1;
  logic [3:0]  grp1, src1;
  logic [2:0]  idx1;
  logic        ord1, ov1;
  logic [4:0]  ovs1, ooff1;
  logic [3:0]  ogrp1, osrc1;
  logic [2:0]  oidx1;
  logic [0:0]  og1;

  read_stage_rr_arbiter_n #(.N_IN(4)) dut4 (
    .clock(clock), .reset(reset),
    .io_in_valid(v4), .io_in_ready(r4),
    .io_in_bits_vs(vs4), .io_in_bits_offset(off4), .io_in_bits_groupIndex(grp4),
    .io_in_bits_readSource(src4), .io_in_bits_instructionIndex(idx4),
    .io_out_ready(ord4), .io_out_valid(ov4),
    .io_out_bits_vs(ovs4), .io_out_bits_offset(ooff4), .io_out_bits_groupIndex(ogrp4),
    .io_out_bits_readSource(osrc4), .io_out_bits_instructionIndex(oidx4),
    .io_out_grant(og4)
  );

  read_stage_rr_arbiter_n #(.N_IN(3)) dut3 (
    .clock(clock), .reset(reset),
    .io_in_valid(v3), .io_in_ready(r3),
    .io_in_bits_vs(vs3), .io_in_bits_offset(off3), .io_in_bits_groupIndex(grp3),
    .io_in_bits_readSource(src3), .io_in_bits_instructionIndex(idx3),
    .io_out_ready(ord3), .io_out_valid(ov3),
    .io_out_bits_vs(ovs3), .io_out_bits_offset(ooff3), .io_out_bits_groupIndex(ogrp3),
    .io_out_bits_readSource(osrc3), .io_out_bits_instructionIndex(oidx3),
    .io_out_grant(og3)
  );

  read_stage_rr_arbiter_n #(.N_IN(1)) dut1 (
    .clock(clock), .reset(reset),
    .io_in_valid(v1), .io_in_ready(r1),
    .io_in_bits_vs(vs1), .io_in_bits_offset(off1), .io_in_bits_groupIndex(grp1),
    .io_in_bits_readSource(src1), .io_in_bits_instructionIndex(idx1),
    .io_out_ready(ord1), .io_out_valid(ov1),
    .io_out_bits_vs(ovs1), .io_out_bits_offset(ooff1), .io_out_bits_groupIndex(ogrp1),
    .io_out_bits_readSource(osrc1), .io_out_bits_instructionIndex(oidx1),
    .io_out_grant(og1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    v4 = '0; ord4 = 1'b0;
    v3 = '0; ord3 = 1'b1;
    v1 = '0; ord1 = 1'b1;
    vs1 = '0; off1 = 5'h02; grp1 = 4'h3; src1 = 4'h4; idx1 = 3'h1;
    for (int i = 0; i < 4; i++) begin
      vs4[i*5 +: 5]  = 5'(i + 1);
      off4[i*5 +: 5] = 5'(i + 8);
      grp4[i*4 +: 4] = 4'(i + 2);
      src4[i*4 +: 4] = 4'(i + 4);
      idx4[i*3 +: 3] = 3'(i);
    end
    for (int i = 0; i < 3; i++) begin
      vs3[i*5 +: 5]  = 5'(i + 1);
      off3[i*5 +: 5] = 5'(i + 8);
      grp3[i*4 +: 4] = 4'(i + 2);
      src3[i*4 +: 4] = 4'(i + 4);
      idx3[i*3 +: 3] = 3'(i);
    end

    // Reset state
    @(negedge clock);
    check("rst_ov4", ov4, 0);
    check("rst_og4", og4, 0);
    check("rst_ovs4", ovs4, 0);
    check("rst_ov3", ov3, 0);
    check("rst_ov1", ov1, 0);
    v4 = 4'hF; ord4 = 1'b1;
    #1 check("rst_ready_gated", r4, 0);

    // All valid, out_ready high: grants 0,1,2,3,0
    @(negedge clock);
    reset = 1'b1;
    #1 check("rr_ready_first", r4, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("rr_ov_%0d", i), ov4, 1);
      check($sformatf("rr_grant_%0d", i), og4, i % 4);
      check($sformatf("rr_vs_%0d", i), ovs4, (i % 4) + 1);
      #1 check($sformatf("rr_ready_%0d", i), r4, 1 << ((i + 1) % 4));
    end
    v4 = '0;

    // Only in2 valid for 3 cycles, then in0+in2
    @(negedge clock);
    check("drain_ov", ov4, 0);
    v4 = 4'b0100;
    #1 check("in2_ready_0", r4, 4'b0100);
    for (int i = 1; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("in2_grant_%0d", i), og4, 2);
      #1 check($sformatf("in2_ready_%0d", i), r4, 4'b0100);
    end
    @(negedge clock);
    check("in2_grant_3", og4, 2);
    v4 = 4'b0101;
    #1 check("in02_ready_a", r4, 4'b0001);
    @(negedge clock);
    check("in02_grant_a", og4, 0);
    #1 check("in02_ready_b", r4, 4'b0100);
    @(negedge clock);
    check("in02_grant_b", og4, 2);

    // Payload pass-through from in1
    vs4[5 +: 5] = 5'h1f; off4[5 +: 5] = 5'h0a; grp4[4 +: 4] = 4'h6;
    src4[4 +: 4] = 4'h3; idx4[3 +: 3] = 3'h5;
    v4 = 4'b0010;
    #1 check("pay_ready", r4, 4'b0010);
    @(negedge clock);
    check("pay_ov", ov4, 1);
    check("pay_vs", ovs4, 5'h1f);
    check("pay_off", ooff4, 5'h0a);
    check("pay_grp", ogrp4, 4'h6);
    check("pay_src", osrc4, 4'h3);
    check("pay_idx", oidx4, 3'h5);
    check("pay_grant", og4, 1);
    v4 = '0;

    // Stall: all valid, out_ready low for 4 cycles (ptr=2 on entry)
    @(negedge clock);
    check("stall_empty", ov4, 0);
    v4 = 4'hF; ord4 = 1'b0;
    #1 check("stall_ready_0", r4, 4'b0100);
    @(negedge clock);
    check("stall_ov_1", ov4, 1);
    check("stall_grant_1", og4, 2);
`ifdef READ_STAGE_ARB_SKID_EN
    #1 check("stall_ready_1", r4, 4'b1000);
`else
    #1 check("stall_ready_1", r4, 4'b0000);
`endif
    for (int i = 2; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("stall_grant_%0d", i), og4, 2);
      check($sformatf("stall_vs_%0d", i), ovs4, 5'd3);
      #1 check($sformatf("stall_ready_%0d", i), r4, 4'b0000);
    end
    @(negedge clock);
    ord4 = 1'b1;
    check("release_grant", og4, 2);
`ifdef READ_STAGE_ARB_SKID_EN
    #1 check("release_ready", r4, 4'b0000);
`else
    #1 check("release_ready", r4, 4'b1000);
`endif
    v4 = '0;
    @(negedge clock);
`ifdef READ_STAGE_ARB_SKID_EN
    check("skid_drain_ov", ov4, 1);
    check("skid_drain_grant", og4, 3);
`else
    check("release_pop_ov", ov4, 0);
`endif
    @(negedge clock);
    check("drained_ov", ov4, 0);

    // Async reset with a stalled valid output
    v4 = 4'hF; ord4 = 1'b0;
    @(negedge clock);
    check("prerst_ov", ov4, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_ov", ov4, 0);
    check("arst_ready", r4, 0);
    check("arst_grant", og4, 0);
    check("arst_vs", ovs4, 0);
    @(negedge clock);
    check("arst_hold_ov", ov4, 0);
    reset = 1'b1; ord4 = 1'b1;
    #1 check("post_rst_ready", r4, 4'b0001);
    @(negedge clock);
    check("post_rst_ov", ov4, 1);
    check("post_rst_grant", og4, 0);
    check("post_rst_vs", ovs4, 5'd1);
    v4 = '0;

    // N_IN=3 wrap: grants 0,1,2,0
    @(negedge clock);
    v3 = 3'b111;
    #1 check("n3_ready_first", r3, 3'b001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("n3_ov_%0d", i), ov3, 1);
      check($sformatf("n3_grant_%0d", i), og3, i % 3);
      check($sformatf("n3_vs_%0d", i), ovs3, (i % 3) + 1);
      #1 check($sformatf("n3_ready_%0d", i), r3, 1 << ((i + 1) % 3));
    end
    v3 = '0;

    // N_IN=1 pass-through
    @(negedge clock);
    check("n3_drained", ov3, 0);
    v1 = 1'b1; vs1 = 5'h15;
    #1 check("n1_ready", r1, 1);
    @(negedge clock);
    check("n1_ov", ov1, 1);
    check("n1_vs_a", ovs1, 5'h15);
    check("n1_off", ooff1, 5'h02);
    check("n1_grant", og1, 0);
    vs1 = 5'h0b;
    @(negedge clock);
    check("n1_vs_b", ovs1, 5'h0b);
    v1 = 1'b0;
    @(negedge clock);
    check("n1_pop_ov", ov1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
